// File: rtl/new_means_calc.sv
// Centroid update: divides each coordinate sum by the cluster point count with
// a bit-serial restoring divider (one quotient bit per cycle, all lanes parallel).

module div_step #(
  parameter int W  = 22,
  parameter int CW = 10
) (
  input  logic [CW-1:0] rem,
  input  logic [W-1:0]  acc,
  input  logic [CW-1:0] div,
  output logic [CW-1:0] rem_nxt,
  output logic [W-1:0]  acc_nxt
);
  logic [CW:0] trial, diff;
  logic        ge;

  always_comb begin
    trial   = {rem, acc[W-1]};
    diff    = trial - {1'b0, div};
    ge      = (trial >= {1'b0, div});
    // remainder stays below the divisor, so CW bits always suffice
    rem_nxt = ge ? diff[CW-1:0] : trial[CW-1:0];
    acc_nxt = {acc[W-2:0], ge};
  end
endmodule

module new_means_calc #(
  parameter int dim              = 7,
  parameter int centroid_num     = 8,
  parameter int log2_cent_num    = 3,
  parameter int accum_cord_width = 22,
  parameter int cordinate_width  = 13,
  parameter int count_width      = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              divider_en,
  input  logic [log2_cent_num-1:0]          cent_cnt,
  input  logic [dim*accum_cord_width-1:0]   accum_in,
  input  logic [count_width-1:0]            count_in,
  input  logic [dim*cordinate_width-1:0]    old_cent_in,
  output logic                              busy,
  output logic                              new_cent_valid,
  output logic [log2_cent_num-1:0]          cent_idx_out,
  output logic [dim*cordinate_width-1:0]    new_cent_out
);
  localparam int W  = accum_cord_width;
  localparam int C  = cordinate_width;
  localparam int SW = $clog2(W);

  if (centroid_num > (1 << log2_cent_num)) begin : g_chk
    $error("log2_cent_num too small for centroid_num");
  end

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t                              state_q, state_d;
  logic [log2_cent_num-1:0]            idx_q, idx_d, idx_out_q, idx_out_d;
  logic [count_width-1:0]              cnt_q, cnt_d;
  logic [SW-1:0]                       step_q, step_d;
  logic [dim-1:0][W-1:0]               acc_q, acc_d, acc_nxt;
  logic [dim-1:0][count_width-1:0]     rem_q, rem_d, rem_nxt;
  logic [dim*C-1:0]                    out_q, out_d;

  for (genvar i = 0; i < dim; i++) begin : g_lane
    div_step #(.W(W), .CW(count_width)) u_step (
      .rem     (rem_q[i]),
      .acc     (acc_q[i]),
      .div     (cnt_q),
      .rem_nxt (rem_nxt[i]),
      .acc_nxt (acc_nxt[i])
    );
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    out_d     = out_q;
    idx_out_d = idx_out_q;
    case (state_q)
      IDLE: if (divider_en) begin
        idx_d  = cent_cnt;
        cnt_d  = count_in;
        step_d = '0;
        rem_d  = '0;
        for (int i = 0; i < dim; i++) acc_d[i] = accum_in[i*W +: W];
        if (count_in != '0) state_d = DIVIDE;
        else begin
          // empty cluster keeps its centroid
          state_d   = DONE;
          out_d     = old_cent_in;
          idx_out_d = cent_cnt;
        end
      end
      DIVIDE: begin
        acc_d  = acc_nxt;
        rem_d  = rem_nxt;
        step_d = step_q + 1'b1;
        if (step_q == SW'(W-1)) begin
          state_d   = DONE;
          idx_out_d = idx_q;
          for (int i = 0; i < dim; i++)
            out_d[i*C +: C] = (|acc_nxt[i][W-1:C]) ? {C{1'b1}} : acc_nxt[i][C-1:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      step_q    <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      out_q     <= '0;
      idx_out_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      out_q     <= out_d;
      idx_out_q <= idx_out_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign new_cent_valid = (state_q == DONE);
  assign cent_idx_out   = idx_out_q;
  assign new_cent_out   = out_q;
endmodule

// File: tb/tb_new_means_calc.sv
// Randomized + directed bench for new_means_calc against a floor/saturate
// arithmetic model of the centroid update.

module tb_new_means_calc;
  localparam int DIM = 7, LW = 3, AW = 22, CW = 13, NW = 10;

  logic                gclk = 1'b0;
  logic                rst_n;
  logic                divider_en;
  logic [LW-1:0]       cent_cnt;
  logic [DIM*AW-1:0]   accum_in;
  logic [NW-1:0]       count_in;
  logic [DIM*CW-1:0]   old_cent_in;
  logic                busy, new_cent_valid;
  logic [LW-1:0]       cent_idx_out;
  logic [DIM*CW-1:0]   new_cent_out;

  int nvec = 0, nerr = 0;

  always #5 gclk = ~gclk;

  new_means_calc dut (
    .clk(gclk), .rst_n(rst_n), .divider_en(divider_en), .cent_cnt(cent_cnt),
    .accum_in(accum_in), .count_in(count_in), .old_cent_in(old_cent_in),
    .busy(busy), .new_cent_valid(new_cent_valid), .cent_idx_out(cent_idx_out),
    .new_cent_out(new_cent_out)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DIM*CW-1:0] model(input logic [DIM*AW-1:0] acc,
      input logic [NW-1:0] cnt, input logic [DIM*CW-1:0] old);
    logic [DIM*CW-1:0] r;
    longint q;
    if (cnt == 0) return old;
    for (int i = 0; i < DIM; i++) begin
      q = longint'(acc[i*AW +: AW]) / longint'(cnt);
      if (q > 8191) q = 8191;
      r[i*CW +: CW] = CW'(q);
    end
    return r;
  endfunction

  // One request; optional stray divider_en while busy at wait cycle ign_at
  task automatic run(input logic [LW-1:0] idx, input logic [DIM*AW-1:0] acc,
      input logic [NW-1:0] cnt, input logic [DIM*CW-1:0] old, input int ign_at);
    logic [DIM*CW-1:0] exp_out;
    int n, exp_n, pulses;
    exp_out = model(acc, cnt, old);
    exp_n   = (cnt == 0) ? 1 : 23;
    @(negedge gclk);
    cent_cnt = idx; accum_in = acc; count_in = cnt; old_cent_in = old;
    divider_en = 1'b1;
    @(negedge gclk);
    divider_en = 1'b0;
    n = 1;
    while (n <= 40 && !new_cent_valid) begin
      chk("busy_div", busy, 1'b1);
      if (n == ign_at) begin
        divider_en = 1'b1; cent_cnt = 3'd5; count_in = 10'd1;
        accum_in = {DIM*AW{1'b1}}; old_cent_in = '0;
      end else divider_en = 1'b0;
      @(negedge gclk);
      n++;
    end
    divider_en = 1'b0;
    chk("latency", n, exp_n);
    chk("valid", new_cent_valid, 1'b1);
    chk("busy_done", busy, 1'b1);
    chk("cent", new_cent_out, exp_out);
    chk("idx", cent_idx_out, idx);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge gclk);
      if (new_cent_valid) pulses++;
    end
    chk("extra_pulse", pulses, 0);
    chk("busy_idle", busy, 1'b0);
    chk("hold_cent", new_cent_out, exp_out);
    chk("hold_idx", cent_idx_out, idx);
  endtask

  function automatic logic [DIM*AW-1:0] fill_acc(input logic [AW-1:0] v);
    logic [DIM*AW-1:0] r;
    for (int i = 0; i < DIM; i++) r[i*AW +: AW] = v;
    return r;
  endfunction

  initial begin
    logic [DIM*AW-1:0] acc;
    logic [DIM*CW-1:0] old;
    logic [NW-1:0]     cnt;
    int sums[DIM];
    int pulses;

    rst_n = 1'b0; divider_en = 1'b0; cent_cnt = '0; accum_in = '0;
    count_in = '0; old_cent_in = '0;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", new_cent_valid, 1'b0);
    chk("rst_cent", new_cent_out, '0);
    chk("rst_idx", cent_idx_out, '0);
    @(negedge gclk); rst_n = 1'b1;

    // basic divide
    run(3'd3, fill_acc(22'd1000), 10'd10, '0, 0);
    // truncation
    sums = '{7, 9, 0, 1, 511, 512, 4095};
    for (int i = 0; i < DIM; i++) acc[i*AW +: AW] = AW'(sums[i]);
    run(3'd1, acc, 10'd4, '0, 0);
    // saturation and max divisor
    run(3'd7, fill_acc(22'h3FFFFF), 10'd1, '0, 0);
    run(3'd2, fill_acc(22'h3FFFFF), 10'd1023, '0, 0);
    // empty cluster
    for (int i = 0; i < DIM; i++) old[i*CW +: CW] = CW'(i + 1);
    run(3'd6, fill_acc(22'd12345), 10'd0, old, 0);
    // request while busy is ignored
    run(3'd0, fill_acc(22'd77777), 10'd33, '0, 5);

    // reset mid-divide
    @(negedge gclk);
    cent_cnt = 3'd4; accum_in = fill_acc(22'd5000); count_in = 10'd7;
    divider_en = 1'b1;
    @(negedge gclk); divider_en = 1'b0;
    repeat (9) @(negedge gclk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_valid", new_cent_valid, 1'b0);
    chk("arst_cent", new_cent_out, '0);
    chk("arst_idx", cent_idx_out, '0);
    @(negedge gclk); rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge gclk);
      if (new_cent_valid) pulses++;
    end
    chk("arst_nopulse", pulses, 0);
    run(3'd4, fill_acc(22'd5000), 10'd7, '0, 0);

    // random traffic
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 5))
        0:       cnt = '0;
        1:       cnt = NW'($urandom_range(1, 3));
        default: cnt = NW'($urandom_range(1, 1023));
      endcase
      for (int i = 0; i < DIM; i++) begin
        acc[i*AW +: AW] = AW'($urandom_range(0, 22'h3FFFFF));
        old[i*CW +: CW] = CW'($urandom_range(0, 8191));
      end
      run(LW'($urandom_range(0, 7)), acc, cnt, old,
          ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 21)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
